// File: rtl/system_mode_controller.sv
// Mode sequencer for the memory shift register: generates exclusive LOAD/RUN/OUTPUT
// controls, counts serial bits and generations, and flags completion with DONE.
//
// state    | meaning
// S_IDLE   | waiting for a request; arbitration RUN > LOAD > OUTPUT
// S_LOAD   | shifting in SERIAL_IN on each SERIAL_VALID cycle until DATA_SIZE bits
// S_RUN    | capturing grid updates for the latched generation count
// S_OUTPUT | rotating the memory for exactly DATA_SIZE cycles, uninterruptible
module system_mode_controller #(
    parameter int DATA_SIZE = 64,
    parameter int GEN_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD_REQ,
    input  logic             SERIAL_VALID,
    input  logic             RUN_REQ,
    input  logic [GEN_W-1:0] GEN_COUNT,
    input  logic             OUTPUT_REQ,
    output logic             LOAD_MODE,
    output logic             RUN_MODE,
    output logic             OUTPUT_MODE,
    output logic             SERIAL_OUT_VALID,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_OUTPUT
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [GEN_W-1:0] gen_cnt, gen_cnt_next;
    logic             done_next;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state            <= S_IDLE;
            bit_cnt          <= '0;
            gen_cnt          <= '0;
            DONE             <= 1'b0;
            SERIAL_OUT_VALID <= 1'b0;
        end else begin
            state            <= state_next;
            bit_cnt          <= bit_cnt_next;
            gen_cnt          <= gen_cnt_next;
            DONE             <= done_next;
            // memory drives SERIAL_OUT from a register, so valid trails the rotate
            SERIAL_OUT_VALID <= OUTPUT_MODE;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        gen_cnt_next = gen_cnt;
        done_next    = 1'b0;
        LOAD_MODE    = 1'b0;
        RUN_MODE     = 1'b0;
        OUTPUT_MODE  = 1'b0;

        case (state)
            S_IDLE: begin
                if (RUN_REQ) begin
                    gen_cnt_next = GEN_COUNT;
                    // zero generations completes without ever leaving IDLE
                    if (GEN_COUNT == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = S_RUN;
                    end
                end else if (LOAD_REQ) begin
                    bit_cnt_next = '0;
                    state_next   = S_LOAD;
                end else if (OUTPUT_REQ) begin
                    bit_cnt_next = '0;
                    state_next   = S_OUTPUT;
                end
            end

            S_LOAD: begin
                LOAD_MODE = SERIAL_VALID;
                if (SERIAL_VALID) begin
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end

            S_RUN: begin
                RUN_MODE     = 1'b1;
                gen_cnt_next = gen_cnt - GEN_W'(1);
                if (gen_cnt == GEN_W'(1)) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end

            S_OUTPUT: begin
                OUTPUT_MODE  = 1'b1;
                bit_cnt_next = bit_cnt + CNT_W'(1);
                if (bit_cnt == LAST_BIT) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_system_mode_controller.sv
// Self-checking bench for system_mode_controller: vector table, directed timing
// sequences, asynchronous reset abort and randomized traffic against an operation model.
module tb_system_mode_controller;

    logic        CLK;
    logic        RESET;
    logic        LOAD_REQ;
    logic        SERIAL_VALID;
    logic        RUN_REQ;
    logic [15:0] GEN_COUNT;
    logic        OUTPUT_REQ;
    logic        LOAD_MODE;
    logic        RUN_MODE;
    logic        OUTPUT_MODE;
    logic        SERIAL_OUT_VALID;
    logic        BUSY;
    logic        DONE;

    system_mode_controller #(.DATA_SIZE(64), .GEN_W(16)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .LOAD_REQ(LOAD_REQ),
        .SERIAL_VALID(SERIAL_VALID),
        .RUN_REQ(RUN_REQ),
        .GEN_COUNT(GEN_COUNT),
        .OUTPUT_REQ(OUTPUT_REQ),
        .LOAD_MODE(LOAD_MODE),
        .RUN_MODE(RUN_MODE),
        .OUTPUT_MODE(OUTPUT_MODE),
        .SERIAL_OUT_VALID(SERIAL_OUT_VALID),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int obs_cyc  = 0;
    logic [5:0] obs;

    // operation-level model: what is in progress and how many cycles/bits remain
    localparam int K_IDLE = 0, K_LOAD = 1, K_RUN = 2, K_OUT = 3;
    int m_kind = K_IDLE;
    int m_left = 0;
    bit m_done = 1'b0;
    bit m_sov  = 1'b0;

    // results of the last run_op
    int n_load, n_run, n_out, n_sov, first_mode, first_sov, done_at, busy_at_done, sv_err;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] dut_vec();
        return {LOAD_MODE, RUN_MODE, OUTPUT_MODE, SERIAL_OUT_VALID, BUSY, DONE};
    endfunction

    function automatic logic [5:0] model_expect();
        logic lm;
        lm = (m_kind == K_LOAD) && SERIAL_VALID;
        return {lm, m_kind == K_RUN, m_kind == K_OUT, m_sov, m_kind != K_IDLE, m_done};
    endfunction

    task automatic model_reset();
        m_kind = K_IDLE;
        m_left = 0;
        m_done = 1'b0;
        m_sov  = 1'b0;
    endtask

    task automatic model_edge();
        bit nd;
        nd    = 1'b0;
        m_sov = (m_kind == K_OUT);
        case (m_kind)
            K_IDLE: begin
                if (RUN_REQ) begin
                    if (GEN_COUNT == 16'd0) nd = 1'b1;
                    else begin
                        m_kind = K_RUN;
                        m_left = int'(GEN_COUNT);
                    end
                end else if (LOAD_REQ) begin
                    m_kind = K_LOAD;
                    m_left = 64;
                end else if (OUTPUT_REQ) begin
                    m_kind = K_OUT;
                    m_left = 64;
                end
            end
            K_LOAD: if (SERIAL_VALID) m_left--;
            default: m_left--;
        endcase
        if (m_kind != K_IDLE && m_left == 0) begin
            m_kind = K_IDLE;
            nd     = 1'b1;
        end
        m_done = nd;
    endtask

    // Entered at posedge+1: apply inputs, compare at negedge, advance across the edge.
    task automatic step(input logic lr, input logic rr, input logic orq, input logic sv,
                        input logic [15:0] gc);
        LOAD_REQ     = lr;
        RUN_REQ      = rr;
        OUTPUT_REQ   = orq;
        SERIAL_VALID = sv;
        GEN_COUNT    = gc;
        @(negedge CLK);
        obs     = dut_vec();
        obs_cyc = cyc;
        check("model_cycle", int'(obs), int'(model_expect()));
        @(posedge CLK);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic run_op(input logic lr, input logic rr, input logic orq,
                          input logic [15:0] gc, input bit toggle, input int budget);
        int  k;
        int  rel;
        logic sv;
        k = cyc;
        step(lr, rr, orq, 1'b0, gc);
        n_load = 0; n_run = 0; n_out = 0; n_sov = 0;
        first_mode = -1; first_sov = -1; done_at = -1; busy_at_done = -1; sv_err = 0;
        for (int i = 0; i < budget && done_at < 0; i++) begin
            sv = toggle ? logic'((i % 2) == 0) : 1'b1;
            step(1'b0, 1'b0, 1'b0, sv, gc);
            rel = obs_cyc - k;
            if (obs[5]) n_load++;
            if (obs[4]) n_run++;
            if (obs[3]) n_out++;
            if ((obs[5] || obs[4] || obs[3]) && first_mode < 0) first_mode = rel;
            if (obs[2]) begin
                n_sov++;
                if (first_sov < 0) first_sov = rel;
            end
            if (lr && obs[1] && (obs[5] !== sv)) sv_err++;
            if (obs[0]) begin
                done_at      = rel;
                busy_at_done = int'(obs[1]);
            end
        end
    endtask

    typedef struct {
        logic        lr;
        logic        rr;
        logic        orq;
        logic        sv;
        logic [15:0] gc;
        logic [5:0]  exp;   // {LOAD_MODE, RUN_MODE, OUTPUT_MODE, SERIAL_OUT_VALID, BUSY, DONE}
    } vec_t;

    vec_t vecs[9];
    int   n_out_first;
    int   seen;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'b000000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 6'b000000};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'b000001};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 6'b000000};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 6'b010010};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 6'b010010};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 6'b000001};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 6'b000000};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 6'b000000};

        RESET = 1'b1; LOAD_REQ = 1'b0; RUN_REQ = 1'b0; OUTPUT_REQ = 1'b0;
        SERIAL_VALID = 1'b0; GEN_COUNT = 16'd0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_outputs", int'(dut_vec()), 0);
        RESET = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].lr, vecs[i].rr, vecs[i].orq, vecs[i].sv, vecs[i].gc);
            check($sformatf("vec%0d", i), int'(obs), int'(vecs[i].exp));
        end

        // continuous load
        run_op(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 200);
        check("load_first", first_mode, 1);
        check("load_bits", n_load, 64);
        check("load_done_at", done_at, 65);
        check("load_busy_at_done", busy_at_done, 0);

        // load with alternating valid
        run_op(1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 300);
        check("gap_load_bits", n_load, 64);
        check("gap_load_done_at", done_at, 128);
        check("gap_load_follow_sv", sv_err, 0);

        run_op(1'b0, 1'b1, 1'b0, 16'd5, 1'b0, 50);
        check("run5_first", first_mode, 1);
        check("run5_cycles", n_run, 5);
        check("run5_done_at", done_at, 6);

        run_op(1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 200);
        check("out_first", first_mode, 1);
        check("out_cycles", n_out, 64);
        check("out_sov_first", first_sov, 2);
        check("out_sov_cycles", n_sov, 64);
        check("out_done_at", done_at, 65);
        n_out_first = n_out;
        run_op(1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 200);
        check("out2_cycles", n_out, n_out_first);
        check("out2_done_at", done_at, 65);

        // abort a readout after 20 bits with an asynchronous reset
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
        seen = 0;
        for (int i = 0; i < 40 && seen < 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            if (obs[3]) seen++;
        end
        check("abort_reached_bit20", seen, 20);
        #2 RESET = 1'b1;
        #1 check("abort_async_clear", int'(dut_vec()), 0);
        model_reset();
        @(posedge CLK);
        #1 RESET = 1'b0;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            check("abort_no_done", int'(obs[0]), 0);
        end
        run_op(1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 200);
        check("post_abort_out_cycles", n_out, 64);
        check("post_abort_done_at", done_at, 65);

        // maximum generation count
        run_op(1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 70000);
        check("run_max_cycles", n_run, 65535);
        check("run_max_done_at", done_at, 65536);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                RESET = 1'b1;
                model_reset();
                @(posedge CLK);
                #1 RESET = 1'b0;
                cyc++;
            end else begin
                step(logic'($urandom_range(0, 6) == 0), logic'($urandom_range(0, 9) == 0),
                     logic'($urandom_range(0, 6) == 0), logic'(($urandom % 4) != 0),
                     16'($urandom_range(0, 8)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
